// File: rtl/mul_div_unit.sv
`default_nettype none
// mul_div_unit: HI/LO multiply/divide unit with a fixed-latency multiplier and a
// radix-2 restoring divider (WIDTH iterations plus one sign-fix cycle). Revision 1.0
module mul_div_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               mul_signed;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               accept;
    logic               signed_div;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               ext_a;
    logic               ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign busy   = (state != IDLE);
    assign accept = start && !busy && !flush && !(op[2] && op[1]);

    assign signed_div = (op == OP_DIV);
    assign a_abs      = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_abs      = (signed_div && b[WIDTH-1]) ? -b : b;

    // Operands are extended to the full product width so the low 2*WIDTH bits
    // of a plain modular multiply are the exact signed or unsigned product.
    assign ext_a   = mul_signed & op_a[WIDTH-1];
    assign ext_b   = mul_signed & op_b[WIDTH-1];
    assign product = {{WIDTH{ext_a}}, op_a} * {{WIDTH{ext_b}}, op_b};

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, op_b};

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            quo        <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU: begin
                                op_a       <= a;
                                op_b       <= b;
                                mul_signed <= (op == OP_MULT);
                                cnt        <= CNT_W'(MUL_LAT - 1);
                                state      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a     <= a;
                                op_b     <= b_abs;
                                quo      <= a_abs;
                                rem      <= '0;
                                neg_q    <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r    <= signed_div && a[WIDTH-1];
                                div_zero <= (b == '0);
                                cnt      <= '0;
                                state    <= DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        {hi, lo} <= product;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        if (div_zero) begin
                            lo <= '1;
                            hi <= op_a;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// tb_mul_div_unit: directed vectors with a done-driven scoreboard for HI/LO results.
module tb_mul_div_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];
    logic        prev_done = 1'b0;

    mul_div_unit #(.WIDTH(W), .MUL_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        logic [63:0] e;
        string       n;
        if (reset && done) begin
            check("done_single_cycle", {63'b0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {hi, lo}, e);
                check({n, "_busy_low"}, {63'b0, busy}, 64'd0);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [63:0] exp, input int lat);
        int n;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        issue(o, x, y);
        wait_idle(n);
        check({nm, "_latency"}, 64'(n), 64'(lat));
        check({nm, "_done"}, {63'b0, done}, 64'd1);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'b0, busy, done}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // First edge after release accepts a start.
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
        check("mthi_first_edge", {hi, lo}, 64'hA5A5_A5A5_0000_0000);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        issue(OP_MTLO, 32'h0000_0055, 32'h0);
        check("mtlo", {hi, lo}, 64'hA5A5_A5A5_0000_0055);
        check("mtlo_no_done", {62'b0, busy, done}, 64'd0);

        run("mult_neg2x3", OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 4);
        run("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4);
        run("mult_minmax", OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 4);
        run("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run("divu_b2b",    OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 33);
        run("divu_by0",    OP_DIVU,  32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 33);
        run("div_by0",     OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 33);
        run("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        run("div_7_m2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);

        // A start while busy must not disturb the running divide.
        exp_q.push_back(64'h0000_0000_0000_0064);
        name_q.push_back("divu_ignore_start");
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(OP_MTHI, 32'h0000_DEAD, 32'h0);
        wait_idle(n);
        check("divu_ignore_start_latency", 64'(n), 64'd29);

        // Flush at busy cycle 10 of a divide.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_hilo_kept", {hi, lo}, 64'h0000_0000_0000_0064);
        check("flush_no_done", {63'b0, done}, 64'd0);
        issue(OP_MTLO, 32'h0000_1234, 32'h0);
        check("mtlo_after_flush", {hi, lo}, 64'h0000_0000_0000_1234);
        check("mtlo_after_flush_busy", {63'b0, busy}, 64'd0);

        // Flush wins over a simultaneous start while idle.
        flush = 1'b1;
        issue(OP_MTHI, 32'hFFFF_0000, 32'h0);
        flush = 1'b0;
        check("flush_start_same_edge", {hi, lo}, 64'h0000_0000_0000_1234);

        issue(3'b110, 32'h1, 32'h2);
        check("reserved_op", {62'b0, busy, done}, 64'd0);
        check("reserved_op_hilo", {hi, lo}, 64'h0000_0000_0000_1234);

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 32'd5, 32'd6);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_busy_done", {62'b0, busy, done}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_idle", {hi, lo}, 64'd0);

        run("mult_post_reset", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 4);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal values 8..64.
REQ-002 Parameter MUL_LAT, default 4, multiply latency in cycles; legal values 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request from E stage; op/a/b valid while high.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-008 b  input  WIDTH  rt operand (divisor / multiplier).
REQ-009 flush  input  1  abort in-flight operation (branch/exception kill of E stage).
REQ-010 busy  output  1  operation in progress; datapath stalls MFHI/MFLO and new starts while high.
REQ-011 done  output  1  one-cycle pulse on the cycle HI/LO become valid after MULT/DIV.
REQ-012 hi  output  WIDTH  registered HI.
REQ-013 lo  output  WIDTH  registered LO.

Function
REQ-014 The unit SHALL use FSM states IDLE, MUL, DIV, FIX; busy SHALL be high exactly when state is not IDLE.
REQ-015 A start is accepted on a rising edge where start=1, busy=0, flush=0 and op is not reserved; otherwise it is ignored with no state change.
REQ-016 MTHI/MTLO SHALL write a into hi/lo on the accepting edge, leave the other register unchanged, keep busy low, and not pulse done.
REQ-017 MULT/MULTU SHALL latch operands, enter MUL, hold busy for exactly MUL_LAT cycles, then write {hi,lo} = full 2*WIDTH product on the edge that returns to IDLE.
REQ-018 MULT SHALL treat operands as two's complement; MULTU as unsigned; no truncation of the product.
REQ-019 DIV/DIVU SHALL be radix-2 restoring: latch magnitudes, WIDTH iteration cycles in DIV, then one FIX cycle applying signs; total busy = WIDTH+1 cycles.
REQ-020 DIV quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend; lo=quotient, hi=remainder.
REQ-021 Divide by zero (b=0): lo = all ones, hi = a; latency unchanged.
REQ-022 DIV overflow (a = -2^(WIDTH-1), b = -1): lo = -2^(WIDTH-1), hi = 0.
REQ-023 done SHALL be high for exactly the one cycle following the edge that writes MULT/DIV results, concurrent with busy low.
REQ-024 flush while busy SHALL return the FSM to IDLE on that edge, discard partial results, leave hi/lo at prior values, and not pulse done.
REQ-025 flush and start on the same edge: flush wins; start ignored.
REQ-026 flush while IDLE SHALL have no effect.
REQ-027 start during busy SHALL be ignored; the in-flight operation continues unaffected.
REQ-028 Back-to-back: a start on the cycle done is high SHALL be accepted.
REQ-029 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap within one operation.

Reset
REQ-030 reset low SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-031 reset asserted mid-operation SHALL discard the operation; no result is written after release.
REQ-032 After reset release, the first rising edge SHALL accept a start.

Verification
REQ-033 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> busy 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
REQ-034 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 4 cycles.
REQ-035 DIV a=-7 (0xFFFFFFF9), b=2 -> after 33 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no X.
REQ-037 Start DIVU 100/7, assert flush at busy cycle 10 -> busy low next cycle, hi/lo retain prior values, no done; MTLO 0x1234 next cycle -> lo=0x00001234, busy stays 0.
REQ-038 Start MULT, drop reset (low) at busy cycle 2 between clock edges -> hi=lo=0, busy=0 immediately; after release no done pulse appears.
